if_fetch: RTL and testbench
===========================

IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL provide: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL provide: rst  in  1  synchronous, active-high reset.
REQ-003 SHALL provide: id_allowin_in  in  1  ID can accept an instruction this cycle.
REQ-004 SHALL provide: id_nextPC_in  in  32  next fetch PC computed by ID (branch target or fast NPC).
REQ-005 SHALL provide: wb_ClrStpJmp_in  in  1  flush; id_nextPC_in then carries the exception/eret target.
REQ-006 SHALL provide: inst_req  out  1, inst_addr  out  32, inst_addr_ok  in  1, inst_data_ok  in  1, inst_rdata  in  32  SRAM-like fetch port.
REQ-007 SHALL provide: if_valid_out  out  1  buffered instruction valid toward ID.
REQ-008 SHALL provide: if_PC_out, if_NPC_out, if_NNPC_out, if_Instruct_out  out  32 each  PC, PC+4, PC+8, instruction word.
REQ-009 SHALL provide: if_NPC_fast_wire  out  32  combinational PC+4 of the held instruction.
REQ-010 SHALL provide: if_exception_out  out  1, if_ExcCode_out  out  5, if_error_VAddr_out  out  32  fetch exception data.

Function
REQ-011 SHALL hold a fetch PC register pc_r; if_PC_out = pc_r, if_NPC_out = if_NPC_fast_wire = pc_r+4, if_NNPC_out = pc_r+8, all modulo 2^32.
REQ-012 SHALL implement states REQ, WAIT, HOLD, CANCEL.
REQ-013 REQ: inst_req=1, inst_addr=pc_r; addr_ok=1 -> WAIT.
REQ-014 REQ with pc_r[1:0]!=0: inst_req=0, no request; next cycle HOLD with exception=1, ExcCode=5'h04 (AdEL), error_VAddr=pc_r, Instruct=0.
REQ-015 WAIT: on inst_data_ok, register inst_rdata into the instruction buffer -> HOLD; a new request is never issued while one is outstanding.
REQ-016 HOLD: if_valid_out=1; on id_allowin_in=1, pc_r <= id_nextPC_in, buffer cleared, -> REQ.
REQ-017 Latency: addr_ok in cycle t, data_ok earliest in t+1, if_valid_out in t+2, next inst_req in t+3 at the earliest.
REQ-018 Flush in REQ: pc_r <= id_nextPC_in; if addr_ok is high that cycle -> CANCEL, else stay REQ with the new address.
REQ-019 Flush in WAIT: pc_r <= id_nextPC_in; -> CANCEL, or -> REQ if data_ok arrives that same cycle (data discarded).
REQ-020 CANCEL: inst_req=0; the next data_ok is discarded -> REQ.
REQ-021 Flush in HOLD: buffer discarded, pc_r <= id_nextPC_in, -> REQ.
REQ-022 if_valid_out SHALL be forced 0 in any cycle where wb_ClrStpJmp_in=1; flush takes priority over handoff.
REQ-023 Exception outputs SHALL be 0 whenever if_valid_out=0.
REQ-024 inst_addr and inst_req SHALL stay stable while inst_req=1 and addr_ok=0, except on a flush (REQ-018).

Reset
REQ-025 rst=1 SHALL set state=REQ, pc_r=32'hBFC0_0000, and buffer/exception registers to 0; if_valid_out=0; inst_req may assert in the first cycle after reset.
REQ-026 rst asserted mid-transaction SHALL abandon any outstanding request; the memory side is reset by the same rst, so no CANCEL is needed.

Structure
REQ-027 Reset PC, AdEL code (5'h04) and the ini_* reset values of the IF outputs SHALL live in the shared defines.vh.
REQ-028 State encoding SHALL be local to if_fetch.
REQ-029 There SHALL be no sub-module; the block is a single FSM plus datapath registers.

Verification
REQ-030 Reset, then addr_ok=1 immediately and data_ok one cycle later with rdata=32'h2408_0001 -> inst_addr=BFC0_0000, HOLD with Instruct=2408_0001, NPC=BFC0_0004, NNPC=BFC0_0008.
REQ-031 HOLD with id_allowin_in=0 for 5 cycles -> outputs stable, inst_req=0; then allowin=1 with id_nextPC_in=BFC0_0100 -> next inst_addr=BFC0_0100.
REQ-032 Flush in WAIT, nextPC=BFC0_0380, stale data_ok=DEAD_BEEF two cycles later -> DEAD_BEEF never appears valid; next request targets BFC0_0380.
REQ-033 id_nextPC_in=BFC0_0102 at handoff -> no inst_req; if_valid_out=1, exception=1, ExcCode=04, error_VAddr=BFC0_0102.
REQ-034 Flush and allowin in the same HOLD cycle -> if_valid_out=0 that cycle; pc_r takes the flush target.
REQ-035 rst pulsed in WAIT -> pc_r=BFC0_0000, state REQ, if_valid_out=0 next cycle.

Source files
------------

// File: rtl/if_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : if_fetch_pkg
// Brief  : Shared IF-stage constants: reset PC, AdEL code, output reset values.
// Rev    : 1.0  initial release
// ============================================================================
package if_fetch_pkg;

  localparam logic [31:0] c_RESET_PC     = 32'hBFC0_0000;
  localparam logic [4:0]  c_EXC_ADEL     = 5'h04;
  localparam logic [31:0] c_INI_INSTRUCT = 32'h0000_0000;
  localparam logic [31:0] c_INI_VADDR    = 32'h0000_0000;
  localparam logic [4:0]  c_INI_EXCCODE  = 5'h00;

endpackage
`default_nettype wire

// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module : if_fetch
// Brief  : Instruction fetch stage: one-outstanding SRAM-like fetch FSM with
//          a single-entry instruction buffer toward ID.
// Rev    : 1.0  initial release
// ============================================================================
module if_fetch
  import if_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_allowin_in,
  input  logic [31:0] id_nextPC_in,
  input  logic        wb_ClrStpJmp_in,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_valid_out,
  output logic [31:0] if_PC_out,
  output logic [31:0] if_NPC_out,
  output logic [31:0] if_NNPC_out,
  output logic [31:0] if_Instruct_out,
  output logic [31:0] if_NPC_fast_wire,
  output logic        if_exception_out,
  output logic [4:0]  if_ExcCode_out,
  output logic [31:0] if_error_VAddr_out
);

  typedef enum logic [1:0] {
    ST_REQ    = 2'd0,
    ST_WAIT   = 2'd1,
    ST_HOLD   = 2'd2,
    ST_CANCEL = 2'd3
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_exc;
  logic [4:0]  r_exccode;
  logic [31:0] r_vaddr;

  logic        w_flush;
  logic        w_misaligned;

  assign w_flush      = wb_ClrStpJmp_in;
  assign w_misaligned = (r_pc[1:0] != 2'b00);

  // Misaligned PCs never reach the bus; they become an AdEL in HOLD instead.
  assign inst_req  = (r_state == ST_REQ) && !w_misaligned;
  assign inst_addr = r_pc;

  assign if_valid_out       = (r_state == ST_HOLD) && !w_flush;
  assign if_PC_out          = r_pc;
  assign if_NPC_fast_wire   = r_pc + 32'd4;
  assign if_NPC_out         = if_NPC_fast_wire;
  assign if_NNPC_out        = r_pc + 32'd8;
  assign if_Instruct_out    = r_inst;
  assign if_exception_out   = r_exc & if_valid_out;
  assign if_ExcCode_out     = if_valid_out ? r_exccode : c_INI_EXCCODE;
  assign if_error_VAddr_out = if_valid_out ? r_vaddr   : c_INI_VADDR;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_REQ;
      r_pc      <= c_RESET_PC;
      r_inst    <= c_INI_INSTRUCT;
      r_exc     <= 1'b0;
      r_exccode <= c_INI_EXCCODE;
      r_vaddr   <= c_INI_VADDR;
    end else begin
      case (r_state)
        ST_REQ: begin
          if (w_flush) begin
            r_pc <= id_nextPC_in;
            // An accepted address still owes us one data beat to swallow.
            if (inst_req && inst_addr_ok) r_state <= ST_CANCEL;
          end else if (w_misaligned) begin
            r_exc     <= 1'b1;
            r_exccode <= c_EXC_ADEL;
            r_vaddr   <= r_pc;
            r_inst    <= c_INI_INSTRUCT;
            r_state   <= ST_HOLD;
          end else if (inst_addr_ok) begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (w_flush) begin
            r_pc    <= id_nextPC_in;
            r_state <= inst_data_ok ? ST_REQ : ST_CANCEL;
          end else if (inst_data_ok) begin
            r_inst  <= inst_rdata;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (w_flush || id_allowin_in) begin
            r_pc      <= id_nextPC_in;
            r_inst    <= c_INI_INSTRUCT;
            r_exc     <= 1'b0;
            r_exccode <= c_INI_EXCCODE;
            r_vaddr   <= c_INI_VADDR;
            r_state   <= ST_REQ;
          end
        end
        ST_CANCEL: begin
          if (w_flush)      r_pc    <= id_nextPC_in;
          if (inst_data_ok) r_state <= ST_REQ;
        end
        default: r_state <= ST_REQ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module : tb_if_fetch
// Brief  : Directed scenarios plus randomized memory/ID/flush traffic checked
//          against a transaction-level model of the fetch stream.
// Rev    : 1.0  initial release
// ============================================================================
module tb_if_fetch;
  import if_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_allowin_in;
  logic [31:0] id_nextPC_in;
  logic        wb_ClrStpJmp_in;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        if_valid_out;
  logic [31:0] if_PC_out;
  logic [31:0] if_NPC_out;
  logic [31:0] if_NNPC_out;
  logic [31:0] if_Instruct_out;
  logic [31:0] if_NPC_fast_wire;
  logic        if_exception_out;
  logic [4:0]  if_ExcCode_out;
  logic [31:0] if_error_VAddr_out;

  if_fetch dut (
    .clk                (clk),
    .rst                (rst),
    .id_allowin_in      (id_allowin_in),
    .id_nextPC_in       (id_nextPC_in),
    .wb_ClrStpJmp_in    (wb_ClrStpJmp_in),
    .inst_req           (inst_req),
    .inst_addr          (inst_addr),
    .inst_addr_ok       (inst_addr_ok),
    .inst_data_ok       (inst_data_ok),
    .inst_rdata         (inst_rdata),
    .if_valid_out       (if_valid_out),
    .if_PC_out          (if_PC_out),
    .if_NPC_out         (if_NPC_out),
    .if_NNPC_out        (if_NNPC_out),
    .if_Instruct_out    (if_Instruct_out),
    .if_NPC_fast_wire   (if_NPC_fast_wire),
    .if_exception_out   (if_exception_out),
    .if_ExcCode_out     (if_ExcCode_out),
    .if_error_VAddr_out (if_error_VAddr_out)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Memory contents are a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h3C1D_0000;
  endfunction

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = {16'hBFC0, 16'($urandom)};
    if ($urandom_range(0, 7) != 0) p[1:0] = 2'b00;
    return p;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    rst             = 1'b0;
    id_allowin_in   = 1'b0;
    id_nextPC_in    = 32'h0;
    wb_ClrStpJmp_in = 1'b0;
    inst_addr_ok    = 1'b0;
    inst_data_ok    = 1'b0;
    inst_rdata      = 32'h0;
  endtask

  logic [31:0] pend[$];
  logic [31:0] exp_pc;
  logic        stall_prev;
  logic [31:0] prev_addr;
  int          idle;
  int          handoffs;

  initial begin
    drive_idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;

    // Reset state and first fetch with immediate addr_ok
    inst_addr_ok = 1'b1;
    @(negedge clk);
    check_eq("rst_valid", 32'(if_valid_out), 32'd0);
    check_eq("rst_pc", if_PC_out, c_RESET_PC);
    check_eq("rst_req", 32'(inst_req), 32'd1);
    check_eq("rst_addr", inst_addr, 32'hBFC0_0000);
    check_eq("rst_exc", 32'(if_exception_out), 32'd0);
    step();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h2408_0001;
    @(negedge clk);
    check_eq("wait_noreq", 32'(inst_req), 32'd0);
    check_eq("wait_valid", 32'(if_valid_out), 32'd0);
    step();
    inst_data_ok = 1'b0;
    inst_rdata   = 32'h0;
    @(negedge clk);
    check_eq("first_valid", 32'(if_valid_out), 32'd1);
    check_eq("first_inst", if_Instruct_out, 32'h2408_0001);
    check_eq("first_npc", if_NPC_out, 32'hBFC0_0004);
    check_eq("first_nnpc", if_NNPC_out, 32'hBFC0_0008);
    check_eq("first_fast", if_NPC_fast_wire, 32'hBFC0_0004);
    check_eq("first_exc", 32'(if_exception_out), 32'd0);

    // Hold while ID stalls
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      check_eq("hold_valid", 32'(if_valid_out), 32'd1);
      check_eq("hold_req", 32'(inst_req), 32'd0);
      check_eq("hold_inst", if_Instruct_out, 32'h2408_0001);
    end
    step();
    id_allowin_in = 1'b1;
    id_nextPC_in  = 32'hBFC0_0100;
    @(negedge clk);
    check_eq("handoff_valid", 32'(if_valid_out), 32'd1);
    step();
    id_allowin_in = 1'b0;
    inst_addr_ok  = 1'b1;
    @(negedge clk);
    check_eq("next_req", 32'(inst_req), 32'd1);
    check_eq("next_addr", inst_addr, 32'hBFC0_0100);

    // Flush in WAIT, stale data two cycles later
    step();
    inst_addr_ok    = 1'b0;
    wb_ClrStpJmp_in = 1'b1;
    id_nextPC_in    = 32'hBFC0_0380;
    @(negedge clk);
    check_eq("flushw_valid", 32'(if_valid_out), 32'd0);
    step();
    wb_ClrStpJmp_in = 1'b0;
    @(negedge clk);
    check_eq("cancel_req", 32'(inst_req), 32'd0);
    step();
    inst_data_ok = 1'b1;
    inst_rdata   = 32'hDEAD_BEEF;
    @(negedge clk);
    check_eq("stale_valid", 32'(if_valid_out), 32'd0);
    check_eq("stale_req", 32'(inst_req), 32'd0);
    step();
    inst_data_ok = 1'b0;
    inst_addr_ok = 1'b1;
    @(negedge clk);
    check_eq("refetch_req", 32'(inst_req), 32'd1);
    check_eq("refetch_addr", inst_addr, 32'hBFC0_0380);
    check_eq("refetch_valid", 32'(if_valid_out), 32'd0);
    step();
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b1;
    inst_rdata   = 32'h1111_2222;
    @(negedge clk);
    step();
    inst_data_ok = 1'b0;
    @(negedge clk);
    check_eq("refetch_hold", 32'(if_valid_out), 32'd1);
    check_eq("refetch_inst", if_Instruct_out, 32'h1111_2222);
    check_eq("refetch_pc", if_PC_out, 32'hBFC0_0380);

    // Misaligned next PC becomes AdEL
    step();
    id_allowin_in = 1'b1;
    id_nextPC_in  = 32'hBFC0_0102;
    @(negedge clk);
    step();
    id_allowin_in = 1'b0;
    @(negedge clk);
    check_eq("adel_noreq", 32'(inst_req), 32'd0);
    check_eq("adel_pre_valid", 32'(if_valid_out), 32'd0);
    step();
    @(negedge clk);
    check_eq("adel_valid", 32'(if_valid_out), 32'd1);
    check_eq("adel_exc", 32'(if_exception_out), 32'd1);
    check_eq("adel_code", 32'(if_ExcCode_out), 32'h04);
    check_eq("adel_vaddr", if_error_VAddr_out, 32'hBFC0_0102);
    check_eq("adel_inst", if_Instruct_out, 32'h0);

    // Flush and allowin in the same HOLD cycle
    step();
    wb_ClrStpJmp_in = 1'b1;
    id_allowin_in   = 1'b1;
    id_nextPC_in    = 32'hBFC0_0200;
    @(negedge clk);
    check_eq("flushh_valid", 32'(if_valid_out), 32'd0);
    check_eq("flushh_exc", 32'(if_exception_out), 32'd0);
    step();
    wb_ClrStpJmp_in = 1'b0;
    id_allowin_in   = 1'b0;
    inst_addr_ok    = 1'b1;
    @(negedge clk);
    check_eq("flushh_pc", if_PC_out, 32'hBFC0_0200);
    check_eq("flushh_req", 32'(inst_req), 32'd1);

    // Reset while WAIT
    step();
    inst_addr_ok = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    check_eq("rstw_noreq", 32'(inst_req), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check_eq("rstw_pc", if_PC_out, c_RESET_PC);
    check_eq("rstw_valid", 32'(if_valid_out), 32'd0);
    check_eq("rstw_req", 32'(inst_req), 32'd1);

    // Randomized traffic against the fetch-stream model
    exp_pc     = c_RESET_PC;
    stall_prev = 1'b0;
    prev_addr  = 32'h0;
    idle       = 0;
    handoffs   = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      step();
      rst             = ($urandom_range(0, 199) == 0);
      wb_ClrStpJmp_in = ($urandom_range(0, 15) == 0);
      id_allowin_in   = 1'($urandom_range(0, 1));
      id_nextPC_in    = rand_pc();
      inst_addr_ok    = 1'($urandom_range(0, 1));
      inst_data_ok    = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
      inst_rdata      = inst_data_ok ? mem_word(pend[0]) : $urandom;
      @(negedge clk);

      if (inst_req) begin
        check_eq("r_addr", inst_addr, exp_pc);
        check_eq("r_one_outstanding", 32'(pend.size()), 32'd0);
      end
      if (stall_prev) begin
        check_eq("r_req_stable", 32'(inst_req), 32'd1);
        check_eq("r_addr_stable", inst_addr, prev_addr);
      end
      if (wb_ClrStpJmp_in)
        check_eq("r_flush_valid", 32'(if_valid_out), 32'd0);
      if (if_valid_out) begin
        check_eq("r_pc", if_PC_out, exp_pc);
        check_eq("r_npc", if_NPC_out, exp_pc + 32'd4);
        check_eq("r_nnpc", if_NNPC_out, exp_pc + 32'd8);
        check_eq("r_fast", if_NPC_fast_wire, exp_pc + 32'd4);
        if (exp_pc[1:0] != 2'b00) begin
          check_eq("r_adel_exc", 32'(if_exception_out), 32'd1);
          check_eq("r_adel_code", 32'(if_ExcCode_out), 32'h04);
          check_eq("r_adel_vaddr", if_error_VAddr_out, exp_pc);
          check_eq("r_adel_inst", if_Instruct_out, 32'h0);
        end else begin
          check_eq("r_exc", 32'(if_exception_out), 32'd0);
          check_eq("r_inst", if_Instruct_out, mem_word(exp_pc));
        end
      end else begin
        check_eq("r_idle_exc", 32'(if_exception_out), 32'd0);
        check_eq("r_idle_code", 32'(if_ExcCode_out), 32'd0);
        check_eq("r_idle_vaddr", if_error_VAddr_out, 32'd0);
      end

      if (rst) begin
        exp_pc = c_RESET_PC;
        pend.delete();
      end else begin
        if (inst_data_ok) void'(pend.pop_front());
        if (inst_req && inst_addr_ok) pend.push_back(inst_addr);
        if (wb_ClrStpJmp_in) exp_pc = id_nextPC_in;
        else if (if_valid_out && id_allowin_in) begin
          exp_pc = id_nextPC_in;
          handoffs++;
        end
      end
      stall_prev = inst_req && !inst_addr_ok && !wb_ClrStpJmp_in && !rst;
      prev_addr  = inst_addr;

      idle = if_valid_out ? 0 : idle + 1;
      if (idle >= 200) begin
        check_eq("fetch_progress", 32'(idle), 32'd0);
        break;
      end
    end
    check_eq("handoff_count", 32'(handoffs > 100), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
